// File: rtl/ram_cfg_pkg.sv
// Shared configuration for the leaf RAM bank.
// Contents:
//   RAM_RESET_ZERO / RAM_RESET_SEQ : reset content modes
//   RAM_DEPTH, RAM_INDEX, RAM_WIDTH,
//   RAM_NUM_WR_PORTS, RAM_NUM_RD_PORTS,
//   RAM_WR_PORTS_LOG               : default geometry of one bank
package ram_cfg_pkg;

  localparam int RAM_RESET_ZERO = 0;
  localparam int RAM_RESET_SEQ  = 1;

  localparam int RAM_DEPTH        = 32;
  localparam int RAM_INDEX        = 5;
  localparam int RAM_WIDTH        = 32;
  localparam int RAM_NUM_WR_PORTS = 4;
  localparam int RAM_NUM_RD_PORTS = 8;
  localparam int RAM_WR_PORTS_LOG = 2;

endpackage

// File: rtl/ram_wr_arbiter.sv
// Per-entry write-port priority select.
// Ports:
//   hitVec   in  NUM_WR_PORTS  ports whose live write targets this entry
//   winIdx   out WR_PORTS_LOG  index of the winning port
//   winValid out 1             at least one port targets this entry
// When several ports hit the same entry the highest-numbered one wins.
module ram_wr_arbiter
  import ram_cfg_pkg::*;
#(
  parameter int NUM_WR_PORTS = RAM_NUM_WR_PORTS,
  parameter int WR_PORTS_LOG = RAM_WR_PORTS_LOG
) (
  input  logic [NUM_WR_PORTS-1:0] hitVec,
  output logic [WR_PORTS_LOG-1:0] winIdx,
  output logic                    winValid
);

  // Ascending scan: a later (higher) hit overrides an earlier one.
  always_comb begin
    winIdx   = '0;
    winValid = 1'b0;
    for (int wp = 0; wp < NUM_WR_PORTS; wp++) begin
      if (hitVec[wp]) begin
        winIdx   = WR_PORTS_LOG'(wp);
        winValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_static_config.sv
// Leaf storage bank: multi-ported register-file RAM with per-port and
// whole-RAM power gating, one-cycle reset initialisation and a ready flag.
// Addresses are partition-relative; partition decode lives in the wrapper.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   writePortGated_i   per write port gate (1 = port disabled)
//   readPortGated_i    per read port gate (1 = data forced to 0)
//   ramGated_i         whole-RAM gate
//   addr_i / data_o    packed read addresses / combinational read data
//   addrWr_i, dataWr_i, wrEn_i  packed write ports
//   ramReady_o         registered ready flag
// Interface contract: there is no valid/ready handshake. Reads are
// combinational and always present; writes take effect at the rising edge.
// ramReady_o is a level: low after any edge with reset high, high from the
// first edge with reset low, and independent of gating.
module ram_static_config
  import ram_cfg_pkg::*;
#(
  parameter int    DEPTH           = RAM_DEPTH,
  parameter int    INDEX           = RAM_INDEX,
  parameter int    WIDTH           = RAM_WIDTH,
  parameter int    NUM_WR_PORTS    = RAM_NUM_WR_PORTS,
  parameter int    NUM_RD_PORTS    = RAM_NUM_RD_PORTS,
  parameter int    WR_PORTS_LOG    = RAM_WR_PORTS_LOG,
  parameter int    RESET_VAL       = RAM_RESET_ZERO,
  parameter int    SEQ_START       = 0,
  parameter int    GATING_ENABLED  = 1,
  parameter int    LATCH_BASED_RAM = 0,
  parameter string PARENT_MODULE   = "NO_PARENT"
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_WR_PORTS-1:0]         writePortGated_i,
  input  logic [NUM_RD_PORTS-1:0]         readPortGated_i,
  input  logic                            ramGated_i,
  input  logic [NUM_RD_PORTS*INDEX-1:0]   addr_i,
  output logic [NUM_RD_PORTS*WIDTH-1:0]   data_o,
  input  logic [NUM_WR_PORTS*INDEX-1:0]   addrWr_i,
  input  logic [NUM_WR_PORTS*WIDTH-1:0]   dataWr_i,
  input  logic [NUM_WR_PORTS-1:0]         wrEn_i,
  output logic                            ramReady_o
);

  // Elaboration-time sanity checks; the parent tag identifies the instance.
  if (DEPTH > (1 << INDEX)) begin : g_bad_depth
    $error("%s: DEPTH exceeds 2**INDEX", PARENT_MODULE);
  end
  if ((LATCH_BASED_RAM != 0) && (LATCH_BASED_RAM != 1)) begin : g_bad_style
    $error("%s: LATCH_BASED_RAM must be 0 or 1", PARENT_MODULE);
  end

  // One extra bit so DEPTH == 2**INDEX is representable.
  localparam logic [INDEX:0] DEPTH_LIM = (INDEX + 1)'(DEPTH);

  // Storage is flops for either storage-style setting, which keeps the
  // read-old-data / write-next-edge timing identical in both cases.
  logic [WIDTH-1:0]        mem [DEPTH];
  logic [NUM_WR_PORTS-1:0] wrGated;
  logic [NUM_RD_PORTS-1:0] rdGated;
  logic [NUM_WR_PORTS-1:0] wrLive;
  logic [WR_PORTS_LOG-1:0] winIdx [DEPTH];
  logic                    winValid [DEPTH];
  logic                    ramReady;

  function automatic logic [WIDTH-1:0] resetWord(input int entry);
    if (RESET_VAL == RAM_RESET_SEQ) return WIDTH'(SEQ_START + entry);
    return '0;
  endfunction

  // Gating only masks port activity; stored contents are never touched.
  if (GATING_ENABLED != 0) begin : g_gate
    assign wrGated = writePortGated_i | {NUM_WR_PORTS{ramGated_i}};
    assign rdGated = readPortGated_i  | {NUM_RD_PORTS{ramGated_i}};
  end else begin : g_no_gate
    assign wrGated = '0;
    assign rdGated = '0;
  end

  // A write is live when enabled, ungated and inside the bank.
  for (genvar wp = 0; wp < NUM_WR_PORTS; wp++) begin : g_wr_live
    assign wrLive[wp] = wrEn_i[wp] && !wrGated[wp] &&
                        ({1'b0, addrWr_i[wp*INDEX +: INDEX]} < DEPTH_LIM);
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    logic [NUM_WR_PORTS-1:0] hit;
    for (genvar wp = 0; wp < NUM_WR_PORTS; wp++) begin : g_hit
      assign hit[wp] = wrLive[wp] &&
                       (addrWr_i[wp*INDEX +: INDEX] == INDEX'(e));
    end
    ram_wr_arbiter #(
      .NUM_WR_PORTS (NUM_WR_PORTS),
      .WR_PORTS_LOG (WR_PORTS_LOG)
    ) u_arb (
      .hitVec   (hit),
      .winIdx   (winIdx[e]),
      .winValid (winValid[e])
    );
  end

  // Reset reloads every entry in one cycle and overrides same-cycle writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= resetWord(e);
      end
      ramReady <= 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (winValid[e]) begin
          mem[e] <= dataWr_i[int'(winIdx[e])*WIDTH +: WIDTH];
        end
      end
      ramReady <= 1'b1;
    end
  end

  assign ramReady_o = ramReady;

  // Combinational read muxes: old data during a same-cycle write,
  // zero for gated ports and for addresses past the end of the bank.
  for (genvar rp = 0; rp < NUM_RD_PORTS; rp++) begin : g_rd
    logic [INDEX-1:0] rdAddr;
    logic             rdZero;
    assign rdAddr = addr_i[rp*INDEX +: INDEX];
    assign rdZero = rdGated[rp] || ({1'b0, rdAddr} >= DEPTH_LIM);
    assign data_o[rp*WIDTH +: WIDTH] = rdZero ? '0 : mem[rdAddr];
  end

endmodule

// File: tb/tb_ram_static_config.sv
// Bench for ram_static_config. Two instances:
//   inst 0: SEQ reset (start 32), DEPTH 32, gating honoured
//   inst 1: ZERO reset, DEPTH 24, gating ignored
// Each step pushes the expected {ready, data} word computed from a plain
// array model; a negedge monitor pops and compares.
module tb_ram_static_config;
  import ram_cfg_pkg::*;

  localparam int NR = 8;
  localparam int NW = 4;
  localparam int W  = 32;
  localparam int IX = 5;
  localparam int EW = NR*W + 1;

  logic clk;
  logic          rst   [2];
  logic [NW-1:0] wg    [2];
  logic [NR-1:0] rg    [2];
  logic          rgAll [2];
  logic [NR*IX-1:0] ra [2];
  logic [NR*W-1:0]  dout [2];
  logic [NW*IX-1:0] wa [2];
  logic [NW*W-1:0]  wd [2];
  logic [NW-1:0]    wen [2];
  logic             rdy [2];

  // Reference model
  logic [W-1:0] mdl [2][32];
  logic mdlReady [2];
  bit   mdlInit  [2];

  logic [EW-1:0] exp0_q[$];
  logic [EW-1:0] exp1_q[$];
  int vectors;
  int miscompares;
  int cycle;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cycle <= cycle + 1;

  ram_static_config #(
    .DEPTH(32), .INDEX(IX), .WIDTH(W), .NUM_WR_PORTS(NW), .NUM_RD_PORTS(NR),
    .WR_PORTS_LOG(2), .RESET_VAL(RAM_RESET_SEQ), .SEQ_START(32),
    .GATING_ENABLED(1), .LATCH_BASED_RAM(0), .PARENT_MODULE("TB_SEQ")
  ) u_dut_seq (
    .clk(clk), .reset(rst[0]), .writePortGated_i(wg[0]),
    .readPortGated_i(rg[0]), .ramGated_i(rgAll[0]), .addr_i(ra[0]),
    .data_o(dout[0]), .addrWr_i(wa[0]), .dataWr_i(wd[0]), .wrEn_i(wen[0]),
    .ramReady_o(rdy[0])
  );

  ram_static_config #(
    .DEPTH(24), .INDEX(IX), .WIDTH(W), .NUM_WR_PORTS(NW), .NUM_RD_PORTS(NR),
    .WR_PORTS_LOG(2), .RESET_VAL(RAM_RESET_ZERO), .SEQ_START(0),
    .GATING_ENABLED(0), .LATCH_BASED_RAM(1), .PARENT_MODULE("TB_ZERO")
  ) u_dut_zero (
    .clk(clk), .reset(rst[1]), .writePortGated_i(wg[1]),
    .readPortGated_i(rg[1]), .ramGated_i(rgAll[1]), .addr_i(ra[1]),
    .data_o(dout[1]), .addrWr_i(wa[1]), .dataWr_i(wd[1]), .wrEn_i(wen[1]),
    .ramReady_o(rdy[1])
  );

  // ---------------- model ----------------
  function automatic int depthOf(input int k);
    return (k == 0) ? 32 : 24;
  endfunction

  function automatic logic [EW-1:0] expWord(input int k);
    logic [EW-1:0] r;
    int a;
    bit gated;
    r = '0;
    r[EW-1] = mdlReady[k];
    for (int rp = 0; rp < NR; rp++) begin
      a = int'(ra[k][rp*IX +: IX]);
      gated = (k == 0) && (rg[k][rp] || rgAll[k]);
      if (!gated && a < depthOf(k)) r[rp*W +: W] = mdl[k][a];
    end
    return r;
  endfunction

  // Writes applied in ascending port order: a later port simply overwrites.
  task automatic mdlEdge(input int k);
    int a;
    bit gated;
    if (rst[k]) begin
      for (int i = 0; i < 32; i++) mdl[k][i] = (k == 0) ? W'(32 + i) : '0;
      mdlReady[k] = 1'b0;
      mdlInit[k] = 1'b1;
    end else begin
      mdlReady[k] = 1'b1;
      for (int wp = 0; wp < NW; wp++) begin
        a = int'(wa[k][wp*IX +: IX]);
        gated = (k == 0) && (wg[k][wp] || rgAll[k]);
        if (wen[k][wp] && !gated && a < depthOf(k)) mdl[k][a] = wd[k][wp*W +: W];
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int k);
    rst[k] = 1'b0; wg[k] = '0; rg[k] = '0; rgAll[k] = 1'b0;
    ra[k] = '0; wa[k] = '0; wd[k] = '0; wen[k] = '0;
  endtask

  task automatic setRd(input int k, input int rp, input int a);
    ra[k][rp*IX +: IX] = IX'(a);
  endtask

  task automatic setWr(input int k, input int wp, input int a, input logic [W-1:0] d);
    wa[k][wp*IX +: IX] = IX'(a);
    wd[k][wp*W +: W] = d;
    wen[k][wp] = 1'b1;
  endtask

  task automatic readAll(input int k, input int base);
    for (int rp = 0; rp < NR; rp++) setRd(k, rp, base + rp);
  endtask

  task automatic step();
    if (mdlInit[0]) exp0_q.push_back(expWord(0));
    if (mdlInit[1]) exp1_q.push_back(expWord(1));
    @(posedge clk);
    mdlEdge(0);
    mdlEdge(1);
    #1;
  endtask

  task automatic randInputs(input int k);
    bit hot;
    idle(k);
    hot = ($urandom_range(0, 2) == 0);
    rst[k] = ($urandom_range(0, 39) == 0);
    wen[k] = NW'($urandom_range(0, 15));
    for (int wp = 0; wp < NW; wp++) begin
      wa[k][wp*IX +: IX] = IX'($urandom_range(0, hot ? 3 : 31));
      wd[k][wp*W +: W] = $urandom;
    end
    for (int rp = 0; rp < NR; rp++) ra[k][rp*IX +: IX] = IX'($urandom_range(0, 31));
    if ($urandom_range(0, 3) == 0) wg[k] = NW'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) rg[k] = NR'($urandom_range(0, 255));
    rgAll[k] = ($urandom_range(0, 9) == 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic checkOut(input int k, input logic [EW-1:0] e);
    logic [EW-1:0] a;
    a = {rdy[k], dout[k]};
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL inst%0d cycle %0d: got ready=%b data=%h, expected ready=%b data=%h",
               k, cycle, a[EW-1], a[EW-2:0], e[EW-1], e[EW-2:0]);
    end
  endtask

  always @(negedge clk) begin
    if (exp0_q.size() > 0) checkOut(0, exp0_q.pop_front());
    if (exp1_q.size() > 0) checkOut(1, exp1_q.pop_front());
  end

  // ---------------- stimulus ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    cycle = 0;
    mdlInit[0] = 1'b0;
    mdlInit[1] = 1'b0;
    idle(0);
    idle(1);

    // Power-up reset (contents unknown before it, so nothing is checked).
    rst[0] = 1'b1; rst[1] = 1'b1;
    step();
    // Still in reset: ready low, SEQ contents visible.
    readAll(0, 0); readAll(1, 0);
    step();
    // Read back every address; ready rises one edge after reset falls.
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int b = 0; b < 32; b += 8) begin
      readAll(0, b); readAll(1, b);
      step();
    end

    // Read-during-write returns old data, new data the next cycle.
    idle(0); idle(1);
    setWr(0, 0, 5, 32'hDEADBEEF); setRd(0, 3, 5);
    step();
    idle(0); setRd(0, 3, 5);
    step();

    // Same-address conflict and distinct-address parallel writes.
    idle(0);
    setWr(0, 1, 7, 32'h11); setWr(0, 3, 7, 32'h33);
    setWr(0, 0, 2, 32'h22); setWr(0, 2, 4, 32'h44);
    step();
    idle(0); setRd(0, 0, 7); setRd(0, 1, 2); setRd(0, 2, 4);
    step();

    // Gated write port leaves the entry unchanged.
    idle(0); setWr(0, 2, 9, 32'h99); wg[0][2] = 1'b1;
    step();
    idle(0); setRd(0, 0, 9);
    step();

    // Gated read port reads zero; other ports unaffected.
    idle(0); for (int rp = 0; rp < NR; rp++) setRd(0, rp, 5);
    rg[0][1] = 1'b1;
    step();

    // Whole-RAM gate: all zero, no writes; contents intact afterwards.
    idle(0); readAll(0, 0); setWr(0, 0, 10, 32'hBAD0BAD0); rgAll[0] = 1'b1;
    step();
    idle(0); readAll(0, 3); setRd(0, 7, 10);
    step();

    // Gating ignored, out-of-range access, mid-operation reset (inst 1).
    idle(0); idle(1);
    wg[1] = '1; rg[1] = '1; rgAll[1] = 1'b1;
    setWr(1, 0, 1, 32'h55); setWr(1, 1, 30, 32'h77); setWr(1, 2, 3, 32'h66);
    readAll(1, 0);
    step();
    idle(1); wg[1] = '1; rg[1] = '1; rgAll[1] = 1'b1;
    readAll(1, 0); setRd(1, 6, 30); setRd(1, 7, 23);
    step();
    idle(1); setWr(1, 0, 3, 32'hAA); rst[1] = 1'b1; setRd(1, 0, 3);
    step();
    idle(1); setRd(1, 0, 3); setRd(1, 1, 1);
    step();
    idle(1); setRd(1, 0, 3);
    step();

    // Randomised traffic on both instances.
    for (int n = 0; n < 500; n++) begin
      randInputs(0);
      randInputs(1);
      step();
    end

    idle(0); idle(1);
    repeat (2) @(posedge clk);
    #1;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expected words left, required 0/0",
               exp0_q.size(), exp1_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
